// File: rtl/bus_window_multi.sv
// bus_window_multi
// Multi-window register bus splitter. One upstream request bus fans out to
// NWIN sub-buses. Each sub-bus sees only accesses inside its own
// power-of-two window. Address bits above the window size are forced to the
// window base, so sub-bus decoders can ignore them.
// Request and response paths each carry 0..4 free-running register stages.
//
// Optional feature, enabled by defining BUS_WINDOW_MISS_ACK_EN:
//   Unmapped requests are acknowledged after REQ_DEPTH+RSP_DEPTH+1 cycles.
//   Reads of unmapped addresses return MISS_DATA.
//   A sticky, saturating 16-bit miss counter (miss_cnt_q) is kept for debug.
//
// Bus field layout, LSB first:
//   bus_in  : CLK, RESET_L, STARTUP, REQ, RD_WR_L, WR_DATA[DW], ADDR[AW]
//   bus_out : ACK, RD_DATA[DW]
module bus_window_multi #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int NWIN = 2,
    parameter logic [NWIN*BUS_ADDR_WIDTH-1:0] BASES = '0,
    parameter logic [NWIN*8-1:0] SIZES = {NWIN{8'd8}},
    parameter int REQ_DEPTH = 1,
    parameter int RSP_DEPTH = 1,
    parameter logic [BUS_DATA_WIDTH-1:0] MISS_DATA = 32'hDEAD_0BAD,
    localparam int BUS_IN_WIDTH = 5 + BUS_DATA_WIDTH + BUS_ADDR_WIDTH,
    localparam int BUS_OUT_WIDTH = 1 + BUS_DATA_WIDTH
) (
    input  logic                          bus_clk,
    input  logic                          bus_reset,
    input  logic [BUS_IN_WIDTH-1:0]       bus_in,
    output logic [BUS_OUT_WIDTH-1:0]      bus_out,
    output logic [NWIN*BUS_IN_WIDTH-1:0]  sub_bus_in,
    input  logic [NWIN*BUS_OUT_WIDTH-1:0] sub_bus_out
);

    localparam int AW = BUS_ADDR_WIDTH;
    localparam int DW = BUS_DATA_WIDTH;

    localparam int F_CLK     = 0;
    localparam int F_RESET_L = 1;
    localparam int F_STARTUP = 2;
    localparam int F_REQ     = 3;
    localparam int F_RD_WR_L = 4;
    localparam int F_WR_DATA = 5;
    localparam int F_ADDR    = 5 + DW;

    localparam int F_ACK     = 0;
    localparam int F_RD_DATA = 1;

    // Stage arrays keep at least one entry so a depth of 0 still elaborates.
    // Those unused flops are bypassed and have no loads.
    localparam int RQ = (REQ_DEPTH > 0) ? REQ_DEPTH : 1;
    localparam int RP = (RSP_DEPTH > 0) ? RSP_DEPTH : 1;

    function automatic logic [AW-1:0] win_mask(input logic [7:0] sz);
        // A shift of AW or more yields zero, so oversized windows cover everything.
        return ~({AW{1'b1}} << sz);
    endfunction

    function automatic logic [AW-1:0] win_base(input int i);
        return BASES[i*AW +: AW];
    endfunction

    function automatic logic [7:0] win_size(input int i);
        return SIZES[i*8 +: 8];
    endfunction

    logic          up_req;
    logic          up_rd_wr_l;
    logic          up_startup;
    logic [DW-1:0] up_wr_data;
    logic [AW-1:0] up_addr;

    assign up_req     = bus_in[F_REQ];
    assign up_rd_wr_l = bus_in[F_RD_WR_L];
    assign up_startup = bus_in[F_STARTUP];
    assign up_wr_data = bus_in[F_WR_DATA +: DW];
    assign up_addr    = bus_in[F_ADDR +: AW];

    // ---------------- decode ----------------
    logic [NWIN-1:0] hit;
    logic [NWIN-1:0] sel;
    logic [NWIN-1:0] req_s0;
    logic [AW-1:0]   addr_s0 [NWIN];

    // Window match, lowest-index priority, and per-window address remap.
    always_comb begin
        hit = '0;
        sel = '0;
        req_s0 = '0;
        for (int i = 0; i < NWIN; i++) begin
            addr_s0[i] = '0;
        end
        for (int i = 0; i < NWIN; i++) begin
            hit[i] = ((up_addr ^ win_base(i)) & ~win_mask(win_size(i))) == '0;
            if (hit[i] && (sel == '0)) begin
                sel[i] = 1'b1;
            end
        end
        for (int i = 0; i < NWIN; i++) begin
            req_s0[i]  = up_req & sel[i];
            addr_s0[i] = (win_base(i) & ~win_mask(win_size(i))) |
                         (up_addr & win_mask(win_size(i)));
        end
    end

    // ---------------- request pipeline ----------------
    logic [NWIN-1:0] req_pipe_d     [RQ];
    logic [NWIN-1:0] req_pipe_q     [RQ];
    logic            rd_wr_l_pipe_d [RQ];
    logic            rd_wr_l_pipe_q [RQ];
    logic [DW-1:0]   wr_data_pipe_d [RQ];
    logic [DW-1:0]   wr_data_pipe_q [RQ];
    logic [AW-1:0]   addr_pipe_d    [RQ][NWIN];
    logic [AW-1:0]   addr_pipe_q    [RQ][NWIN];

    // Shift request stages forward every cycle; there is no stall.
    always_comb begin
        req_pipe_d[0]     = req_s0;
        rd_wr_l_pipe_d[0] = up_rd_wr_l;
        wr_data_pipe_d[0] = up_wr_data;
        addr_pipe_d[0]    = addr_s0;
        for (int s = 1; s < RQ; s++) begin
            req_pipe_d[s]     = req_pipe_q[s-1];
            rd_wr_l_pipe_d[s] = rd_wr_l_pipe_q[s-1];
            wr_data_pipe_d[s] = wr_data_pipe_q[s-1];
            addr_pipe_d[s]    = addr_pipe_q[s-1];
        end
    end

    // Request stage registers; reset drops any request in flight.
    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            for (int s = 0; s < RQ; s++) begin
                req_pipe_q[s]     <= '0;
                rd_wr_l_pipe_q[s] <= 1'b0;
                wr_data_pipe_q[s] <= '0;
                for (int i = 0; i < NWIN; i++) begin
                    addr_pipe_q[s][i] <= '0;
                end
            end
        end else begin
            req_pipe_q     <= req_pipe_d;
            rd_wr_l_pipe_q <= rd_wr_l_pipe_d;
            wr_data_pipe_q <= wr_data_pipe_d;
            addr_pipe_q    <= addr_pipe_d;
        end
    end

    logic [NWIN-1:0] req_o;
    logic            rd_wr_l_o;
    logic [DW-1:0]   wr_data_o;
    logic [AW-1:0]   addr_o [NWIN];

    // Select either the combinational decode or the last request stage.
    always_comb begin
        if (REQ_DEPTH == 0) begin
            req_o     = req_s0;
            rd_wr_l_o = up_rd_wr_l;
            wr_data_o = up_wr_data;
            addr_o    = addr_s0;
        end else begin
            req_o     = req_pipe_q[RQ-1];
            rd_wr_l_o = rd_wr_l_pipe_q[RQ-1];
            wr_data_o = wr_data_pipe_q[RQ-1];
            addr_o    = addr_pipe_q[RQ-1];
        end
    end

    // Assemble each sub-bus request; housekeeping fields bypass the pipeline.
    always_comb begin
        sub_bus_in = '0;
        for (int i = 0; i < NWIN; i++) begin
            sub_bus_in[i*BUS_IN_WIDTH + F_CLK]            = bus_clk;
            sub_bus_in[i*BUS_IN_WIDTH + F_RESET_L]        = ~bus_reset;
            sub_bus_in[i*BUS_IN_WIDTH + F_STARTUP]        = up_startup;
            sub_bus_in[i*BUS_IN_WIDTH + F_REQ]            = req_o[i];
            sub_bus_in[i*BUS_IN_WIDTH + F_RD_WR_L]        = rd_wr_l_o;
            sub_bus_in[i*BUS_IN_WIDTH + F_WR_DATA +: DW]  = wr_data_o;
            sub_bus_in[i*BUS_IN_WIDTH + F_ADDR +: AW]     = addr_o[i];
        end
    end

    // ---------------- response pipeline ----------------
    logic [BUS_OUT_WIDTH-1:0] rsp_or;
    logic [BUS_OUT_WIDTH-1:0] rsp_pipe_d [RP];
    logic [BUS_OUT_WIDTH-1:0] rsp_pipe_q [RP];
    logic [BUS_OUT_WIDTH-1:0] rsp_o;

    // Idle sub-buses drive zero, so a plain OR merges the responses.
    always_comb begin
        rsp_or = '0;
        for (int i = 0; i < NWIN; i++) begin
            rsp_or = rsp_or | sub_bus_out[i*BUS_OUT_WIDTH +: BUS_OUT_WIDTH];
        end
    end

    // Shift response stages forward every cycle.
    always_comb begin
        rsp_pipe_d[0] = rsp_or;
        for (int s = 1; s < RP; s++) begin
            rsp_pipe_d[s] = rsp_pipe_q[s-1];
        end
    end

    // Response stage registers.
    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            for (int s = 0; s < RP; s++) begin
                rsp_pipe_q[s] <= '0;
            end
        end else begin
            rsp_pipe_q <= rsp_pipe_d;
        end
    end

    // Select either the combinational OR or the last response stage.
    always_comb begin
        rsp_o = (RSP_DEPTH == 0) ? rsp_or : rsp_pipe_q[RP-1];
    end

    logic unused_bits;

`ifdef BUS_WINDOW_MISS_ACK_EN
    // ---------------- miss responder ----------------
    localparam int ML = REQ_DEPTH + RSP_DEPTH + 1;

    logic                     miss_in;
    logic                     miss_vld_d [ML];
    logic                     miss_vld_q [ML];
    logic                     miss_rd_d  [ML];
    logic                     miss_rd_q  [ML];
    logic [15:0]              miss_cnt_d;
    logic [15:0]              miss_cnt_q;
    logic [BUS_OUT_WIDTH-1:0] miss_word;

    assign miss_in = up_req & (sel == '0);
    assign unused_bits = ^{bus_in[F_CLK], bus_in[F_RESET_L]};

    // Miss delay line matches the mapped round trip; the counter saturates.
    always_comb begin
        miss_vld_d[0] = miss_in;
        miss_rd_d[0]  = up_rd_wr_l;
        for (int s = 1; s < ML; s++) begin
            miss_vld_d[s] = miss_vld_q[s-1];
            miss_rd_d[s]  = miss_rd_q[s-1];
        end
        miss_cnt_d = miss_cnt_q;
        if (miss_in && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    // Miss delay line and counter registers.
    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            for (int s = 0; s < ML; s++) begin
                miss_vld_q[s] <= 1'b0;
                miss_rd_q[s]  <= 1'b0;
            end
            miss_cnt_q <= '0;
        end else begin
            miss_vld_q <= miss_vld_d;
            miss_rd_q  <= miss_rd_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // One-cycle synthetic ack when a miss leaves the delay line.
    always_comb begin
        miss_word = '0;
        if (miss_vld_q[ML-1]) begin
            miss_word[F_ACK] = 1'b1;
            miss_word[F_RD_DATA +: DW] = miss_rd_q[ML-1] ? MISS_DATA : '0;
        end
    end

    // Merge the synthetic miss ack into the upstream response.
    always_comb begin
        bus_out = rsp_o | miss_word;
    end
`else
    assign unused_bits = ^{bus_in[F_CLK], bus_in[F_RESET_L], MISS_DATA};

    // Upstream response is just the merged sub-bus responses.
    always_comb begin
        bus_out = rsp_o;
    end
`endif

endmodule

// File: doc/bus_window_multi.md
Name: bus_window_multi

Overview:
- Parametrised multi-window bus splitter: one upstream register bus fans out to NWIN sub-buses, each focused on its own power-of-two address window.
- Request and response paths each have a configurable pipeline depth (0..4 register stages).
- Sub-bus addresses keep full register addresses. Bits above each window's size are forced to that window's base, so sub-bus decoders shrink.
- Sits between the top-level bus master and groups of register blocks, in the same place as the single-window delayed splitter, and replaces it.

Parameters:
- NWIN, 2, number of windows (1..8).
- BASES, 0, packed NWIN*BUS_ADDR_WIDTH; window i base at bits [i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH].
- SIZES, 8'd8 per window, packed NWIN*8; window i spans (1<<SIZES[i*8 +: 8]) bytes.
- REQ_DEPTH, 1, register stages on the request path (0..4; 0 = combinational).
- RSP_DEPTH, 1, register stages on the response path (0..4).
- MISS_DATA, 32'hDEAD_0BAD, read data returned for unmatched reads (MISS_ACK feature only).

Ports:
- bus_clk  input  1  clock for all block registers; also forwarded to every sub-bus CLK field.
- bus_reset  input  1  asynchronous active-high reset.
- bus_in  input  BUS_IN_WIDTH  upstream request bus (req, rd_wr_l, wr_data, addr, startup fields used).
- bus_out  output  BUS_OUT_WIDTH  upstream response bus.
- sub_bus_in  output  NWIN*BUS_IN_WIDTH  per-window request buses; window i at [i*BUS_IN_WIDTH +: BUS_IN_WIDTH].
- sub_bus_out  input  NWIN*BUS_OUT_WIDTH  per-window response buses, same packing.

Behaviour:
- Sub-bus housekeeping fields, all combinational:
  - CLK field = bus_clk.
  - RESET_L field = ~bus_reset.
  - STARTUP field = upstream STARTUP field.
- Decode:
  - hit[i] = ((addr ^ base_i) & ~((1<<size_i)-1)) == 0, i.e. the address's upper bits match the window base.
  - Overlapping windows: the lowest index wins. sel is one-hot or zero.
- Request pipeline, REQ_DEPTH stages:
  - Each stage registers req_i = req & sel[i] per window, plus rd_wr_l, wr_data and a per-window remapped addr.
  - Remapped addr = (base_i & ~mask_i) | (addr & mask_i), where mask_i = (1<<size_i)-1.
  - Non-selected windows get req=0. Their rd_wr_l/wr_data/addr still update every cycle.
  - REQ_DEPTH=0: all sub_bus_in fields are combinational from bus_in.
- Response pipeline:
  - Responses are the bitwise OR of all NWIN sub_bus_out vectors.
  - The OR result passes through RSP_DEPTH register stages to bus_out. Idle sub-buses drive all-zero.
- Latency: upstream-visible latency added = REQ_DEPTH + RSP_DEPTH cycles on top of the target's own latency.
- Reset:
  - All pipeline registers clear to 0 asynchronously on bus_reset, so bus_out = 0 and every sub req = 0 while in reset.
  - The miss tracker returns to IDLE.
  - A request in flight at reset is dropped; no ack is produced afterwards.
- Back-to-back: one request per cycle is accepted. Stages are free-running shift registers with no stall; upstream must not reissue before ack, per bus protocol.

Optional Feature:
- Macro: BUS_WINDOW_MISS_ACK_EN.
- Enabled — miss responder:
  - A request with sel==0 enters a miss delay line of REQ_DEPTH+RSP_DEPTH+1 stages, built as a shift register of (valid, rd_wr_l).
  - On exit it ORs into bus_out for one cycle: ACK field = 1, and RD_DATA = MISS_DATA if rd_wr_l=1, else 0.
  - Unmapped accesses therefore never hang the master.
- Enabled — miss counter:
  - A sticky 16-bit miss counter saturates at 16'hFFFF and clears only on reset.
  - The count is not visible on ports; it is a debug register for the waveform and ILA.
- Disabled: no miss logic is present. Unmatched requests produce no response, and bus_out is purely the OR of the sub responses.

Test Plan:
- NWIN=2, BASES={0x1000,0x0000}, SIZES={8,8}, REQ_DEPTH=1. Write to 0x1034 data 0xA5 -> one cycle later: sub 1 req=1, addr=0x1034, data=0xA5; sub 0 req=0.
- Window 0 base 0x2000 size 4. Read 0x200F -> sub 0 addr=0x200F. Read 0x2010 -> no sub req, since it is outside the window.
- Overlapping windows 0 (0x0000,size 16) and 1 (0x0100,size 8). Access 0x0120 -> only window 0 req asserted.
- REQ_DEPTH=2, RSP_DEPTH=2. Target acks with data 0x1234 on the cycle after its req -> bus_out ack+0x1234 appears 5 cycles after the upstream req.
- BUS_WINDOW_MISS_ACK_EN defined, REQ_DEPTH=1, RSP_DEPTH=1. Read of unmapped 0xF000 -> ack with data 0xDEAD0BAD exactly 3 cycles later, miss counter=1. Repeat without the macro -> bus_out stays 0.
- Assert bus_reset in the cycle after a mapped req -> all sub reqs and bus_out drop to 0 immediately. No ack appears after release, and no miss ack appears.
